sram_req_arb: RTL
=================

SRAM_REQ_ARB -- requirements
Module: sram_req_arb

Interface
REQ-001 Parameter AHB_DWIDTH, default 32, data width of all wdata/rdata ports.
REQ-002 Parameter ADD_WIDTH, default 11, byte-address width of all addr ports.
REQ-003 Parameter TIMEOUT_CYC, default 15, legal range 1..255, maximum WAIT cycles before an error completion.
REQ-004 HCLK  input  1  clock; all state changes on rising edge.
REQ-005 aresetn  input  1  reset, asynchronous, active-low.
REQ-006 mN_req  input  1  requester N (N=0,1) request; held high with attributes stable until mN_ack.
REQ-007 mN_write  input  1  requester N write(1)/read(0).
REQ-008 mN_size  input  3  requester N transfer size (000 byte, 001 half, 010 word).
REQ-009 mN_addr  input  ADD_WIDTH  requester N byte address.
REQ-010 mN_wdata  input  AHB_DWIDTH  requester N write data.
REQ-011 mN_ack  output  1  one-cycle completion pulse to requester N.
REQ-012 mN_err  output  1  timeout flag, valid only with mN_ack.
REQ-013 mN_rdata  output  AHB_DWIDTH  read data, valid only with mN_ack on a read.
REQ-014 s_req, s_write, s_size, s_addr, s_wdata  output  1/1/3/ADD_WIDTH/AHB_DWIDTH  request bundle to the SRAM controller.
REQ-015 s_ack  input  1  controller completion pulse; s_rdata  input  AHB_DWIDTH  controller read data, valid the cycle after s_ack.
REQ-016 arb_gnt  output  2  one-hot owner of the current transaction, 00 when IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: when any mN_req is high, pick a winner, latch its write/size/addr/wdata into the s_* registers and its index into owner, then go to ISSUE; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: with one request, that requester wins; with both, the requester not granted last wins; the last-grant register resets to 1, so m0 wins the first contention.
REQ-020 ISSUE: s_req=1 for exactly this cycle, clear the timeout counter, then go to WAIT.
REQ-021 WAIT: on s_ack=1, go to RESP with err=0; otherwise increment the counter, and when it reaches TIMEOUT_CYC go to RESP with err=1.
REQ-022 RESP: assert m<owner>_ack=1 and m<owner>_err=err for one cycle, then go to IDLE; the other requester's ack/err SHALL stay 0.
REQ-023 m<owner>_rdata SHALL equal s_rdata in RESP for a read with err=0; otherwise all mN_rdata are 0.
REQ-024 s_write/s_size/s_addr/s_wdata SHALL change only on an IDLE grant and SHALL remain stable through ISSUE, WAIT and RESP.
REQ-025 s_ack outside WAIT, including a late ack after a timeout, SHALL be ignored without a state change.
REQ-026 Latency: request seen in IDLE at cycle t gives s_req at t+1; with s_ack at t+2, mN_ack is at t+3; minimum 4 cycles per transaction.
REQ-027 Requester changes of mN_req while not in IDLE SHALL have no effect; a requester that keeps mN_req high after its ack is treated as a new request.
REQ-028 arb_gnt SHALL be the one-hot owner in ISSUE, WAIT and RESP, and 00 in IDLE.
REQ-029 The counter SHALL be 8 bits wide and SHALL saturate, never wrap.

Reset
REQ-030 aresetn low SHALL force IDLE, last-grant=1, counter=0, err=0, and all outputs 0 immediately, including mid-transaction; no ack is issued for an aborted transaction.
REQ-031 After aresetn rises, the first grant SHALL occur no earlier than the first rising edge with aresetn high.

Verification
REQ-032 m0 word write addr 0x010 wdata 0xA5A5A5A5, s_ack at t+2 -> s_req at t+1 with stable bundle; m0_ack=1 and m0_err=0 at t+3; m1_ack stays 0.
REQ-033 m1 byte read addr 0x013, s_ack at t+2, s_rdata=0x11223344 at t+3 -> m1_ack=1 and m1_rdata=0x11223344 at t+3; s_size=000 and s_addr=0x013 throughout.
REQ-034 m0 and m1 both request continuously from reset -> grant order m0, m1, m0, m1; arb_gnt 01, 10, 01, 10; no lost or duplicate acks.
REQ-035 m0 read, s_ack never asserted, TIMEOUT_CYC=15 -> m0_ack=1, m0_err=1, m0_rdata=0 after 15 WAIT cycles; a later stray s_ack leaves the FSM in IDLE.
REQ-036 aresetn pulsed low in WAIT -> all outputs 0 in the same cycle, no mN_ack; after release, a pending m1 request is granted normally.

Source files
------------

// File: rtl/sram_req_arb.sv
// rtl/sram_req_arb.sv - two-requester round-robin arbiter in front of a single SRAM controller port
// One transaction at a time: IDLE grant, ISSUE pulse, WAIT for ack or timeout, RESP completion.
module sram_req_arb #(
  parameter int AHB_DWIDTH  = 32,
  parameter int ADD_WIDTH   = 11,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  HCLK,
  input  logic                  aresetn,

  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [2:0]            m0_size,
  input  logic [ADD_WIDTH-1:0]  m0_addr,
  input  logic [AHB_DWIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [AHB_DWIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [2:0]            m1_size,
  input  logic [ADD_WIDTH-1:0]  m1_addr,
  input  logic [AHB_DWIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [AHB_DWIDTH-1:0] m1_rdata,

  output logic                  s_req,
  output logic                  s_write,
  output logic [2:0]            s_size,
  output logic [ADD_WIDTH-1:0]  s_addr,
  output logic [AHB_DWIDTH-1:0] s_wdata,
  input  logic                  s_ack,
  input  logic [AHB_DWIDTH-1:0] s_rdata,

  output logic [1:0]            arb_gnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  logic [1:0] state;
  logic       owner;
  logic       last_gnt;
  logic [7:0] wait_cnt;
  logic       err;

  logic       any_req;
  logic       pick;
  logic [7:0] cnt_inc;
  logic       in_txn;
  logic       in_resp;
  logic       rd_ok;

  // With both requesting, the one not granted last wins.
  always_comb begin
    any_req = m0_req | m1_req;
    pick    = (m0_req & m1_req) ? ~last_gnt : m1_req;
    cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
      s_write  <= 1'b0;
      s_size   <= 3'd0;
      s_addr   <= '0;
      s_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner    <= pick;
            last_gnt <= pick;
            s_write  <= pick ? m1_write : m0_write;
            s_size   <= pick ? m1_size  : m0_size;
            s_addr   <= pick ? m1_addr  : m0_addr;
            s_wdata  <= pick ? m1_wdata : m0_wdata;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= 8'd0;
          err      <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // An ack on the final counted cycle still completes cleanly.
          if (s_ack) begin
            err   <= 1'b0;
            state <= ST_RESP;
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc >= TIMEOUT_LIM) begin
              err   <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_txn   = (state != ST_IDLE);
    in_resp  = (state == ST_RESP);
    rd_ok    = in_resp & ~s_write & ~err;
    s_req    = (state == ST_ISSUE);
    arb_gnt  = in_txn ? (owner ? 2'b10 : 2'b01) : 2'b00;
    m0_ack   = in_resp & ~owner;
    m1_ack   = in_resp &  owner;
    m0_err   = m0_ack & err;
    m1_err   = m1_ack & err;
    m0_rdata = (rd_ok & ~owner) ? s_rdata : '0;
    m1_rdata = (rd_ok &  owner) ? s_rdata : '0;
  end

endmodule
